pipelined_add_sub: RTL and testbench

//  Parametrised successor to the single-bit adder: a WIDTH-bit adder/subtractor.
//  The carry chain is split into CHUNK-bit stages, with one register per stage.
//  A valid/ready handshake on both sides supports back-pressure.

---
 rtl/add_pkg.sv | 13 +
 rtl/chunk_adder.sv | 21 ++
 rtl/pipelined_add_sub.sv | 127 ++++++++++++
 tb/tb_pipelined_add_sub.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/add_pkg.sv
// Shared types and helpers for the pipelined adder/subtractor.
package add_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  function automatic int stages(input int width, input int chunk);
    return width / chunk;
  endfunction

endpackage

// File: rtl/chunk_adder.sv
// Combinational CHUNK-bit adder slice: sum, carry-out and carry into its MSB.
module chunk_adder #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             c_i,
  output logic [CHUNK-1:0] s_o,
  output logic             c_o,
  output logic             cmsb_o
);

  logic [CHUNK:0] sum;

  assign sum    = {1'b0, a_i} + {1'b0, b_i} + {{CHUNK{1'b0}}, c_i};
  assign s_o    = sum[CHUNK-1:0];
  assign c_o    = sum[CHUNK];
  // The carry into the MSB is recovered from the MSB half-sum instead of a second adder.
  assign cmsb_o = a_i[CHUNK-1] ^ b_i[CHUNK-1] ^ sum[CHUNK-1];

endmodule

// File: rtl/pipelined_add_sub.sv
// WIDTH-bit adder/subtractor with the carry chain split into CHUNK-bit pipeline
// stages, valid/ready on both sides and a global stall.
module pipelined_add_sub
  import add_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             SUB,
  input  logic             CIN,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] S,
  output logic             C,
  output logic             OVF
);

  localparam int STAGES = stages(WIDTH, CHUNK);
  localparam int LAST   = STAGES - 1;

  if ((WIDTH % CHUNK) != 0 || STAGES < 1 || STAGES > 16) begin : g_bad_cfg
    $error("pipelined_add_sub: WIDTH must be a multiple of CHUNK giving 1..16 stages");
  end

  op_e              op;
  logic             advance;

  logic [WIDTH-1:0] x_in [STAGES];
  logic [WIDTH-1:0] b_in [STAGES];
  logic             c_in [STAGES];
  logic             v_in [STAGES];

  logic [CHUNK-1:0] s_c  [STAGES];
  logic             co_c [STAGES];
  logic             cm_c [STAGES];
  logic [WIDTH-1:0] x_d  [STAGES];

  // x_q holds finished sum chunks below the stage and untouched A chunks above it.
  logic [WIDTH-1:0] x_q  [STAGES];
  logic [WIDTH-1:0] b_q  [STAGES];
  logic             c_q  [STAGES];
  logic             vld_q[STAGES];

  logic [WIDTH-1:0] s_q;
  logic             c_out_q;
  logic             ovf_q;

  assign op        = op_e'(SUB);
  assign advance   = !vld_q[LAST] || OUT_READY;
  assign IN_READY  = advance;
  assign OUT_VALID = vld_q[LAST];
  assign S         = s_q;
  assign C         = c_out_q;
  assign OVF       = ovf_q;

  always_comb begin
    x_in[0] = A;
    b_in[0] = (op == OP_SUB) ? ~B : B;
    c_in[0] = (op == OP_SUB) ? 1'b1 : CIN;
    v_in[0] = IN_VALID;
    for (int k = 1; k < STAGES; k++) begin
      x_in[k] = x_q[k-1];
      b_in[k] = b_q[k-1];
      c_in[k] = c_q[k-1];
      v_in[k] = vld_q[k-1];
    end
  end

  for (genvar g = 0; g < STAGES; g++) begin : g_chunk
    chunk_adder #(.CHUNK(CHUNK)) u_chunk (
      .a_i    (x_in[g][g*CHUNK +: CHUNK]),
      .b_i    (b_in[g][g*CHUNK +: CHUNK]),
      .c_i    (c_in[g]),
      .s_o    (s_c[g]),
      .c_o    (co_c[g]),
      .cmsb_o (cm_c[g])
    );
  end

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      x_d[k] = x_in[k];
      x_d[k][k*CHUNK +: CHUNK] = s_c[k];
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int k = 0; k < STAGES; k++) vld_q[k] <= 1'b0;
    end else if (advance) begin
      for (int k = 0; k < STAGES; k++) vld_q[k] <= v_in[k];
    end
  end

  // Skew registers between stages; contents of invalid stages are don't-care.
  always_ff @(posedge CLK) begin
    if (advance) begin
      for (int k = 0; k < LAST; k++) begin
        if (v_in[k]) begin
          x_q[k] <= x_d[k];
          b_q[k] <= b_in[k];
          c_q[k] <= co_c[k];
        end
      end
    end
  end

  // Final stage: result registers change only when a valid result is loaded.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s_q     <= '0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (advance && v_in[LAST]) begin
      s_q     <= x_d[LAST];
      c_out_q <= co_c[LAST];
      ovf_q   <= co_c[LAST] ^ cm_c[LAST];
    end
  end

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Directed and scoreboard bench for pipelined_add_sub (WIDTH=16, CHUNK=4).
module tb_pipelined_add_sub;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        IN_VALID = 1'b0;
  logic        IN_READY;
  logic [15:0] A = '0;
  logic [15:0] B = '0;
  logic        SUB = 1'b0;
  logic        CIN = 1'b0;
  logic        OUT_VALID;
  logic        OUT_READY = 1'b1;
  logic [15:0] S;
  logic        C;
  logic        OVF;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 CLK = ~CLK;

  pipelined_add_sub #(.WIDTH(16), .CHUNK(4)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .A         (A),
    .B         (B),
    .SUB       (SUB),
    .CIN       (CIN),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .S         (S),
    .C         (C),
    .OVF       (OVF)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain 17-bit addition, overflow from operand/result signs.
  function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic sub, input logic cin);
    logic [15:0] bb;
    logic [16:0] full;
    logic        ovf;
    bb   = sub ? ~b : b;
    full = {1'b0, a} + {1'b0, bb} + {16'd0, (sub ? 1'b1 : cin)};
    ovf  = (a[15] == bb[15]) && (full[15] != a[15]);
    return {full[15:0], full[16], ovf};
  endfunction

  task automatic step;
    @(posedge CLK);
    #1;
  endtask

  task automatic drain;
    IN_VALID  = 1'b0;
    OUT_READY = 1'b1;
    step;
    step;
  endtask

  task automatic do_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic sub, input logic cin, input logic [17:0] exp);
    int lat;
    OUT_READY = 1'b1;
    IN_VALID  = 1'b1;
    A = a; B = b; SUB = sub; CIN = cin;
    #1;
    check({tag, "_inrdy"}, IN_READY, 1);
    step;
    IN_VALID = 1'b0;
    lat = 1;
    while (!OUT_VALID && lat < 10) begin
      step;
      lat++;
    end
    check({tag, "_lat"}, lat, 4);
    check({tag, "_res"}, {S, C, OVF}, exp);
  endtask

  task automatic run_stream(input string tag, input int stall_at, input int exp_span);
    logic [15:0] sa [8];
    logic [15:0] sb [8];
    logic        ss [8];
    logic        sc [8];
    int          sent, got, cyc, first, last;
    logic        held_vld;
    logic [17:0] held, obs;
    for (int i = 0; i < 8; i++) begin
      sa[i] = 16'(16'h1111 * (i + 7));
      sb[i] = 16'(16'h2345 + i * 16'h0F01);
      ss[i] = i[0];
      sc[i] = i[1];
    end
    drain;
    sent = 0; got = 0; cyc = 0; first = -1; last = -1;
    held_vld = 1'b0; held = '0;
    while (got < 8 && cyc < 60) begin
      OUT_READY = !(stall_at >= 0 && cyc >= stall_at && cyc < stall_at + 3);
      IN_VALID  = (sent < 8);
      if (sent < 8) begin
        A = sa[sent]; B = sb[sent]; SUB = ss[sent]; CIN = sc[sent];
      end
      #1;
      obs = {S, C, OVF};
      check({tag, "_inrdy"}, IN_READY, OUT_READY);
      if (held_vld) check({tag, "_hold"}, obs, held);
      if (OUT_VALID && OUT_READY) begin
        check({tag, "_res"}, obs, model(sa[got], sb[got], ss[got], sc[got]));
        if (first < 0) first = cyc;
        last = cyc;
        got++;
      end
      held_vld = OUT_VALID && !OUT_READY;
      held     = obs;
      if (IN_VALID && IN_READY) sent++;
      step;
      cyc++;
    end
    check({tag, "_count"}, got, 8);
    check({tag, "_first"}, first, 4);
    check({tag, "_span"}, last - first, exp_span);
    IN_VALID  = 1'b0;
    OUT_READY = 1'b1;
  endtask

  task automatic run_reset_midop;
    drain;
    OUT_READY = 1'b0;
    for (int i = 0; i < 4; i++) begin
      IN_VALID = 1'b1;
      A = (i == 0) ? 16'hFFFF : 16'(16'h0101 * i);
      B = (i == 0) ? 16'hFFFF : 16'h0F0F;
      SUB = 1'b0; CIN = 1'b0;
      step;
    end
    IN_VALID = 1'b0;
    check("rst_pre_vld", OUT_VALID, 1);
    check("rst_pre_res", {S, C, OVF}, {16'hFFFE, 1'b1, 1'b0});
    RST_N = 1'b0;
    #1;
    check("rst_vld", OUT_VALID, 0);
    check("rst_res", {S, C, OVF}, 18'd0);
    check("rst_inrdy", IN_READY, 1);
    step;
    step;
    check("rst_hold_vld", OUT_VALID, 0);
    RST_N = 1'b1;
    step;
    do_op("post_rst", 16'h1234, 16'h1111, 1'b0, 1'b0, {16'h2345, 1'b0, 1'b0});
  endtask

  task automatic run_random(input int n);
    logic [17:0] q[$];
    logic [17:0] e;
    int          sent, got, cyc;
    drain;
    sent = 0; got = 0; cyc = 0;
    while (got < n && cyc < 60000) begin
      IN_VALID  = (sent < n) && ($urandom_range(3) != 0);
      A         = 16'($urandom);
      B         = 16'($urandom);
      SUB       = 1'($urandom);
      CIN       = 1'($urandom);
      OUT_READY = 1'($urandom);
      #1;
      if (OUT_VALID && OUT_READY) begin
        e = (q.size() > 0) ? q.pop_front() : 18'bx;
        check("rnd_res", {S, C, OVF}, e);
        got++;
      end
      if (IN_VALID && IN_READY) begin
        q.push_back(model(A, B, SUB, CIN));
        sent++;
      end
      step;
      cyc++;
    end
    check("rnd_count", got, n);
    check("rnd_left", q.size(), 0);
    IN_VALID  = 1'b0;
    OUT_READY = 1'b1;
  endtask

  initial begin
    RST_N = 1'b0;
    step;
    step;
    check("reset_vld", OUT_VALID, 0);
    check("reset_res", {S, C, OVF}, 18'd0);
    check("reset_inrdy", IN_READY, 1);
    RST_N = 1'b1;
    step;

    do_op("add_carry4",  16'h00FF, 16'h0001, 1'b0, 1'b0, {16'h0100, 1'b0, 1'b0});
    do_op("add_wrap",    16'hFFFF, 16'h0001, 1'b0, 1'b0, {16'h0000, 1'b1, 1'b0});
    do_op("add_cin_ovf", 16'h7FFF, 16'h0000, 1'b0, 1'b1, {16'h8000, 1'b0, 1'b1});
    do_op("sub_borrow",  16'h0005, 16'h0007, 1'b1, 1'b0, {16'hFFFE, 1'b0, 1'b0});
    do_op("sub_ovf",     16'h8000, 16'h0001, 1'b1, 1'b0, {16'h7FFF, 1'b1, 1'b1});
    do_op("sub_cin_ign", 16'h0003, 16'h0003, 1'b1, 1'b1, {16'h0000, 1'b1, 1'b0});

    run_stream("stream_full", -1, 7);
    run_stream("stream_stall", 6, 10);

    run_reset_midop;

    run_random(10000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
